id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode/operand-read stage that produces the operand bundle consumed by the execute stage: rd/rs values, sign-extended immediate, opcode, one-hot class controls and immf.
- Holds the 32x32 register file, written by writeback, and a busy-bit scoreboard for read-after-write hazards.
- Sits between fetch (upstream) and execute (downstream), using the valid/stall pipeline handshake on both sides.

Parameters:
- XLEN, 32, data width
- NREG, 32, register count (address width log2(NREG) = 5)
- IMM_W, 14, raw immediate field width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- inst_i  in  32  instruction from fetch
- v_i  in  1  inst_i valid
- stall_o  out  1  fetch must hold inst_i
- wb_we_i  in  1  writeback write enable
- wb_addr_i  in  5  writeback register
- wb_data_i  in  32  writeback data
- rd_value_o  out  32  value of register rd
- rs_value_o  out  32  value of register rs
- imm_value_o  out  32  sign-extended imm
- opcode_o  out  8  opcode
- ctrl_inte_o / ctrl_logic_o / ctrl_shift_o / ctrl_ld_o / ctrl_st_o / ctrl_br_o  out  1 each  class one-hot
- immf_o  out  1  immediate form
- v_o  out  1  bundle valid
- stall_i  in  1  execute cannot accept

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset state:
  - v_o = 0; all data and ctrl outputs = 0.
  - Busy bits cleared; all registers cleared to 0.
- Instruction format:
  - opcode = inst[31:24]; rd = inst[23:19]; rs = inst[18:14].
  - imm = inst[13:0], sign-extended to 32 bits.
  - Class = opcode[7:5]: 000 inte, 001 logic, 010 shift, 011 ld, 100 st, 101 br.
  - Class 110 or 111 is illegal: issued as a valid bundle with all ctrl = 0 and no busy bit set.
  - immf = opcode[4].
- Operand sources:
  - All classes read rd.
  - rs is read only when immf = 0.
  - Classes inte, logic, shift and ld write rd.
- Register file and bypass:
  - r0 always reads 0; writes to r0 are ignored.
  - Writeback is write-first: a same-cycle wb_we_i to the register being read is forwarded to the captured value.
- Hazard: asserted when v_i = 1 and a read source has busy = 1, unless the same-cycle writeback clears that register.
- Output register:
  - Advances when v_o = 0 or stall_i = 0; otherwise all outputs hold stable.
  - stall_o = (v_o & stall_i) | hazard (combinational).
  - Issue = v_i & ~stall_o. On issue, the bundle is registered and v_o = 1 on the next edge; latency is 1 cycle.
  - If the register advances without an issue (no v_i, or hazard), v_o = 0 (bubble).
- Scoreboard:
  - On issue of a writing class with rd != 0, set busy[rd].
  - wb_we_i clears busy[wb_addr_i].
  - A simultaneous set and clear of the same register leaves it set (the newer writer wins).
- rst asserted mid-stall discards the pending bundle and all busy bits.

Decomposition:
- Shared package holds:
  - Class encodings (CLS_INTE..CLS_BR), field bit positions, XLEN/NREG/IMM_W.
  - The ctrl bundle struct.
- Sub-module regfile_2r1w: two combinational read ports, one synchronous write port, write-first bypass, r0 hardwired to zero.
- Decoder and scoreboard stay in id_stage.

Test Plan:
- Issue and sign-extension: reset; inst = opcode 0x10 (inte, immf), rd = 3, imm = 0x3FFF, v_i = 1 -> next cycle v_o = 1, ctrl_inte_o = 1, immf_o = 1, imm_value_o = 0xFFFFFFFF, busy[3] = 1.
- Write-first bypass: wb_we_i = 1, wb_addr_i = 5, wb_data_i = 0xDEADBEEF in the same cycle an instruction reads rs = 5 -> rs_value_o = 0xDEADBEEF.
- RAW hazard: issue add with rd = 4, then an instruction reading rd = 4 -> stall_o = 1 and a bubble (v_o = 0) each cycle until wb writes r4; the instruction issues the same cycle as that wb, with the new value.
- Downstream backpressure: stall_i = 1 while v_o = 1 for 3 cycles -> outputs stable, stall_o = 1, no busy changes; release -> next bundle follows with no loss or duplication.
- Illegal and r0 handling: opcode 0xE0 -> v_o = 1, all ctrl = 0, no busy set; wb write to r0 with 0x1234 -> r0 still reads 0.
- Reset mid-operation: rst asserted during a hazard stall -> v_o = 0, all busy bits cleared, all registers read 0 afterwards.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode/operand-read stage: widths, field positions,
// instruction classes and the one-hot control bundle.
package id_stage_pkg;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int IMM_W = 14;
    localparam int AW    = $clog2(NREG);
    localparam int OP_W  = 8;

    localparam int OP_LSB   = 24;
    localparam int RD_LSB   = 19;
    localparam int RS_LSB   = 14;
    localparam int IMM_LSB  = 0;
    localparam int IMMF_BIT = 4;

    typedef enum logic [2:0] {
        CLS_INTE  = 3'd0,
        CLS_LOGIC = 3'd1,
        CLS_SHIFT = 3'd2,
        CLS_LD    = 3'd3,
        CLS_ST    = 3'd4,
        CLS_BR    = 3'd5,
        CLS_ILL6  = 3'd6,
        CLS_ILL7  = 3'd7
    } cls_e;

    typedef struct packed {
        logic inte;
        logic logic_op;
        logic shift;
        logic ld;
        logic st;
        logic br;
    } ctrl_t;

    // Illegal classes fall through to an all-zero control bundle.
    function automatic ctrl_t decode_ctrl(input cls_e cls);
        ctrl_t c;
        c = '0;
        case (cls)
            CLS_INTE:  c.inte     = 1'b1;
            CLS_LOGIC: c.logic_op = 1'b1;
            CLS_SHIFT: c.shift    = 1'b1;
            CLS_LD:    c.ld       = 1'b1;
            CLS_ST:    c.st       = 1'b1;
            CLS_BR:    c.br       = 1'b1;
            default:   c          = '0;
        endcase
        return c;
    endfunction

    function automatic logic writes_rd(input cls_e cls);
        return (cls == CLS_INTE) || (cls == CLS_LOGIC) ||
               (cls == CLS_SHIFT) || (cls == CLS_LD);
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch, writeback and execute-side signals of the decode stage.
// The slave modport is the decode stage itself; master is its surroundings.
interface id_stage_if;
    import id_stage_pkg::*;

    logic [XLEN-1:0] inst_i;
    logic            v_i;
    logic            stall_o;

    logic            wb_we_i;
    logic [AW-1:0]   wb_addr_i;
    logic [XLEN-1:0] wb_data_i;

    logic [XLEN-1:0] rd_value_o;
    logic [XLEN-1:0] rs_value_o;
    logic [XLEN-1:0] imm_value_o;
    logic [OP_W-1:0] opcode_o;
    logic            ctrl_inte_o;
    logic            ctrl_logic_o;
    logic            ctrl_shift_o;
    logic            ctrl_ld_o;
    logic            ctrl_st_o;
    logic            ctrl_br_o;
    logic            immf_o;
    logic            v_o;
    logic            stall_i;

    modport master (
        output inst_i, v_i, wb_we_i, wb_addr_i, wb_data_i, stall_i,
        input  stall_o, rd_value_o, rs_value_o, imm_value_o, opcode_o,
               ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o,
               ctrl_st_o, ctrl_br_o, immf_o, v_o
    );

    modport slave (
        input  inst_i, v_i, wb_we_i, wb_addr_i, wb_data_i, stall_i,
        output stall_o, rd_value_o, rs_value_o, imm_value_o, opcode_o,
               ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o,
               ctrl_st_o, ctrl_br_o, immf_o, v_o
    );

endinterface

// File: rtl/id_stage_regfile_2r1w.sv
// Register file with two combinational read ports and one synchronous write port.
// Reads see a same-cycle write (write-first); r0 is hardwired to zero.
module regfile_2r1w
    import id_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra_addr,
    output logic [XLEN-1:0] ra_data,
    input  logic [AW-1:0]   rb_addr,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        ra_data = '0;
        if (ra_addr != '0) begin
            ra_data = (we && (waddr == ra_addr)) ? wdata : regs[ra_addr];
        end
    end

    always_comb begin
        rb_data = '0;
        if (rb_addr != '0) begin
            rb_data = (we && (waddr == rb_addr)) ? wdata : regs[rb_addr];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode/operand-read stage: decodes the instruction, reads operands with
// write-first bypass, tracks pending writers in a busy-bit scoreboard.
module id_stage
    import id_stage_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    id_stage_if.slave bus
);

    logic [OP_W-1:0] opcode;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs;
    logic [XLEN-1:0] imm_ext;
    cls_e            cls;
    logic            immf;
    ctrl_t           ctrl;

    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] rs_val;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            rd_busy;
    logic            rs_busy;
    logic            hazard;
    logic            stall;
    logic            advance;
    logic            issue;

    logic            v_q;
    logic [XLEN-1:0] rd_value_q;
    logic [XLEN-1:0] rs_value_q;
    logic [XLEN-1:0] imm_value_q;
    logic [OP_W-1:0] opcode_q;
    ctrl_t           ctrl_q;
    logic            immf_q;

    assign opcode  = bus.inst_i[OP_LSB +: OP_W];
    assign rd      = bus.inst_i[RD_LSB +: AW];
    assign rs      = bus.inst_i[RS_LSB +: AW];
    assign imm_ext = {{(XLEN-IMM_W){bus.inst_i[IMM_LSB+IMM_W-1]}}, bus.inst_i[IMM_LSB +: IMM_W]};
    assign cls     = cls_e'(opcode[OP_W-1 -: 3]);
    assign immf    = opcode[IMMF_BIT];
    assign ctrl    = decode_ctrl(cls);

    regfile_2r1w u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (rd),
        .ra_data (rd_val),
        .rb_addr (rs),
        .rb_data (rs_val),
        .we      (bus.wb_we_i),
        .waddr   (bus.wb_addr_i),
        .wdata   (bus.wb_data_i)
    );

    // A writeback landing this cycle resolves the hazard on its register.
    assign rd_busy = busy[rd] & ~(bus.wb_we_i && (bus.wb_addr_i == rd));
    assign rs_busy = busy[rs] & ~(bus.wb_we_i && (bus.wb_addr_i == rs));
    assign hazard  = bus.v_i & (rd_busy | (~immf & rs_busy));

    assign advance = ~v_q | ~bus.stall_i;
    assign stall   = (v_q & bus.stall_i) | hazard;
    assign issue   = bus.v_i & ~stall;

    // Clear first, then set, so a new writer overrides a retiring one.
    always_comb begin
        busy_next = busy;
        if (bus.wb_we_i) begin
            busy_next[bus.wb_addr_i] = 1'b0;
        end
        if (issue && writes_rd(cls) && (rd != '0)) begin
            busy_next[rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= 1'b0;
            rd_value_q  <= '0;
            rs_value_q  <= '0;
            imm_value_q <= '0;
            opcode_q    <= '0;
            ctrl_q      <= '0;
            immf_q      <= 1'b0;
        end else if (advance) begin
            v_q <= issue;
            if (issue) begin
                rd_value_q  <= rd_val;
                rs_value_q  <= rs_val;
                imm_value_q <= imm_ext;
                opcode_q    <= opcode;
                ctrl_q      <= ctrl;
                immf_q      <= immf;
            end
        end
    end

    assign bus.stall_o      = stall;
    assign bus.v_o          = v_q;
    assign bus.rd_value_o   = rd_value_q;
    assign bus.rs_value_o   = rs_value_q;
    assign bus.imm_value_o  = imm_value_q;
    assign bus.opcode_o     = opcode_q;
    assign bus.ctrl_inte_o  = ctrl_q.inte;
    assign bus.ctrl_logic_o = ctrl_q.logic_op;
    assign bus.ctrl_shift_o = ctrl_q.shift;
    assign bus.ctrl_ld_o    = ctrl_q.ld;
    assign bus.ctrl_st_o    = ctrl_q.st;
    assign bus.ctrl_br_o    = ctrl_q.br;
    assign bus.immf_o       = immf_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios then random traffic, all checked
// against an array-based model of registers, pending writers and the output bundle.
module tb_id_stage;

    logic clk;
    logic rst;

    id_stage_if bus();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    logic        m_pend [32];
    logic        m_v;
    logic        m_zero;
    logic [31:0] m_rd, m_rs, m_imm;
    logic [7:0]  m_op;
    logic [5:0]  m_ctrl;
    logic        m_immf;
    logic        last_stall;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input int rdn, input int rsn, input int imm);
        logic [4:0]  a;
        logic [4:0]  b;
        logic [13:0] c;
        a = 5'(rdn);
        b = 5'(rsn);
        c = 14'(imm);
        return {op, a, b, c};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        m_v = 0; m_zero = 1; m_rd = 0; m_rs = 0; m_imm = 0; m_op = 0; m_ctrl = 0; m_immf = 0;
    endtask

    // One clock cycle: drive, check stall_o, update the model, check the registered bundle.
    task automatic applyStimulus(input logic r, input logic [31:0] inst, input logic v,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic si);
        int          cls, rdn, rsn, imm14;
        logic        immf, rd_wait, rs_wait, hz, exp_stall, iss;
        logic [31:0] rdv, rsv;
        rst = r;
        bus.inst_i = inst; bus.v_i = v;
        bus.wb_we_i = we; bus.wb_addr_i = wa; bus.wb_data_i = wd;
        bus.stall_i = si;
        #1;
        cls   = int'(inst[31:29]);
        immf  = inst[28];
        rdn   = int'(inst[23:19]);
        rsn   = int'(inst[18:14]);
        imm14 = int'(inst[13:0]);
        rd_wait = m_pend[rdn] && !(we && int'(wa) == rdn);
        rs_wait = m_pend[rsn] && !(we && int'(wa) == rsn);
        hz = v && (rd_wait || (!immf && rs_wait));
        exp_stall = (m_v && si) || hz;
        checkOutput("stall_o", 32'(bus.stall_o), 32'(exp_stall));
        iss = v && !exp_stall;
        if (r) begin
            modelReset();
        end else begin
            rdv = (rdn == 0) ? 32'd0 : ((we && int'(wa) == rdn) ? wd : m_regs[rdn]);
            rsv = (rsn == 0) ? 32'd0 : ((we && int'(wa) == rsn) ? wd : m_regs[rsn]);
            if (!m_v || !si) begin
                m_v = iss;
                if (iss) begin
                    m_zero = 0;
                    m_rd = rdv; m_rs = rsv; m_op = inst[31:24]; m_immf = immf;
                    m_imm = (imm14 >= 8192) ? 32'(imm14 - 16384) : 32'(imm14);
                    m_ctrl = (cls < 6) ? (6'b100000 >> cls) : 6'b000000;
                end
            end
            if (we && wa != 0) m_regs[wa] = wd;
            if (we) m_pend[wa] = 1'b0;
            if (iss && cls <= 3 && rdn != 0) m_pend[rdn] = 1'b1;
        end
        last_stall = v && exp_stall;
        @(posedge clk);
        #1;
        checkOutput("v_o", 32'(bus.v_o), 32'(m_v));
        if (m_v || m_zero) begin
            checkOutput("rd_value_o", bus.rd_value_o, m_rd);
            if (!m_immf) checkOutput("rs_value_o", bus.rs_value_o, m_rs);
            checkOutput("imm_value_o", bus.imm_value_o, m_imm);
            checkOutput("opcode_o", 32'(bus.opcode_o), 32'(m_op));
            checkOutput("immf_o", 32'(bus.immf_o), 32'(m_immf));
            checkOutput("ctrl", 32'({bus.ctrl_inte_o, bus.ctrl_logic_o, bus.ctrl_shift_o,
                                     bus.ctrl_ld_o, bus.ctrl_st_o, bus.ctrl_br_o}), 32'(m_ctrl));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 32'd0, 0, 0, 5'd0, 32'd0, 0);
    endtask

    initial begin
        logic [31:0] inst;
        logic        v, we, si, r;
        logic [4:0]  wa;
        logic [31:0] wd;

        modelReset();
        last_stall = 0;
        applyStimulus(1, 32'd0, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(1, 32'd0, 0, 0, 5'd0, 32'd0, 0);
        checkOutput("reset_v", 32'(bus.v_o), 32'd0);
        checkOutput("reset_rd", bus.rd_value_o, 32'd0);

        // Issue with negative immediate; r3 becomes pending.
        applyStimulus(0, mk(8'h10, 3, 0, 14'h3FFF), 1, 0, 5'd0, 32'd0, 0);
        checkOutput("t1_inte", 32'(bus.ctrl_inte_o), 32'd1);
        checkOutput("t1_imm", bus.imm_value_o, 32'hFFFF_FFFF);
        applyStimulus(0, mk(8'h10, 3, 0, 1), 1, 0, 5'd0, 32'd0, 0);
        checkOutput("t1_busy3", 32'(bus.stall_o), 32'd1);
        applyStimulus(0, mk(8'h10, 3, 0, 1), 1, 1, 5'd3, 32'h0000_0333, 0);
        checkOutput("t1_wb3", bus.rd_value_o, 32'h0000_0333);

        // Same-cycle writeback forwarded to rs.
        applyStimulus(0, mk(8'h20, 0, 5, 0), 1, 1, 5'd5, 32'hDEAD_BEEF, 0);
        checkOutput("t2_bypass", bus.rs_value_o, 32'hDEAD_BEEF);

        // RAW hazard on r4 released by its writeback.
        applyStimulus(0, mk(8'h00, 4, 0, 0), 1, 0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, mk(8'h20, 7, 4, 0), 1, 0, 5'd0, 32'd0, 0);
        checkOutput("t3_bubble", 32'(bus.v_o), 32'd0);
        applyStimulus(0, mk(8'h20, 7, 4, 0), 1, 1, 5'd4, 32'hCAFE_0004, 0);
        checkOutput("t3_rs", bus.rs_value_o, 32'hCAFE_0004);

        // Backpressure: held bundle, then the next one exactly once.
        applyStimulus(0, mk(8'h70, 0, 0, 14'h0055), 1, 0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, mk(8'hB0, 0, 0, 14'h0066), 1, 0, 5'd0, 32'd0, 1);
        checkOutput("t4_hold", bus.imm_value_o, 32'h0000_0055);
        applyStimulus(0, mk(8'hB0, 0, 0, 14'h0066), 1, 0, 5'd0, 32'd0, 1);
        applyStimulus(0, mk(8'hB0, 0, 0, 14'h0066), 1, 0, 5'd0, 32'd0, 0);
        checkOutput("t4_next", 32'(bus.opcode_o), 32'h0000_00B0);
        idle(2);

        // Illegal class sets nothing pending; r0 ignores writes.
        applyStimulus(0, mk(8'hE0, 9, 0, 0), 1, 0, 5'd0, 32'd0, 0);
        checkOutput("t5_ill_v", 32'(bus.v_o), 32'd1);
        applyStimulus(0, mk(8'h00, 9, 0, 0), 1, 1, 5'd0, 32'h0000_1234, 0);
        checkOutput("t5_nobusy", 32'(bus.v_o), 32'd1);
        applyStimulus(0, mk(8'h20, 0, 0, 0), 1, 0, 5'd0, 32'd0, 0);
        checkOutput("t5_r0", bus.rs_value_o, 32'd0);

        // Reset in the middle of a hazard stall.
        applyStimulus(0, mk(8'h00, 10, 0, 0), 1, 0, 5'd0, 32'd0, 0);
        applyStimulus(0, mk(8'h20, 11, 10, 0), 1, 0, 5'd0, 32'd0, 0);
        applyStimulus(1, mk(8'h20, 11, 10, 0), 1, 0, 5'd0, 32'd0, 0);
        checkOutput("t6_v", 32'(bus.v_o), 32'd0);
        applyStimulus(0, mk(8'h20, 10, 5, 0), 1, 0, 5'd0, 32'd0, 0);
        checkOutput("t6_r5", bus.rs_value_o, 32'd0);

        // Random traffic on a small register window so hazards occur often.
        inst = 32'd0;
        v = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!last_stall) begin
                inst = mk(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom));
                v = ($urandom_range(0, 9) < 7);
            end
            we = ($urandom_range(0, 9) < 4);
            wa = 5'($urandom_range(0, 7));
            wd = $urandom;
            si = ($urandom_range(0, 9) < 3);
            r  = ($urandom_range(0, 199) == 0);
            applyStimulus(r, inst, v, we, wa, wd, si);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
